// File: rtl/hpi_bus_sequencer.sv
// hpi_bus_sequencer
//
// Bridges an Avalon-MM slave port onto an asynchronous HPI host bus.
// Each Avalon access is stretched into a fixed-timing HPI cycle:
// SETUP (cs_n low, address/data valid), STROBE (rd_n or wr_n low),
// HOLD (strobe released, cs_n still low), RECOVER (cs_n high).
// The Avalon master is stalled with waitrequest until the last HOLD cycle.
//
// Parameters (each must be 1..15):
//   SETUP_CYC     cycles of address/data setup before the strobe
//   STROBE_CYC    cycles with the strobe asserted
//   HOLD_CYC      cycles with cs_n low after the strobe rises
//   RECOVERY_CYC  cycles with cs_n high between transactions
//
// Ports:
//   clk, reset_n         system clock, async active-low reset
//   avs_*                Avalon-MM slave (address, chipselect, read, write,
//                        writedata, readdata, waitrequest)
//   hpi_addr/cs_n/rd_n/wr_n   HPI control outputs
//   hpi_data_out/oe      HPI write data and its tristate enable
//   hpi_data_in          HPI read data
//   hpi_int, irq         raw HPI interrupt, synchronized interrupt

module hpi_bus_sequencer #(
    parameter int SETUP_CYC    = 1,
    parameter int STROBE_CYC   = 4,
    parameter int HOLD_CYC     = 1,
    parameter int RECOVERY_CYC = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  avs_address,
    input  logic        avs_chipselect,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [15:0] avs_writedata,
    output logic [15:0] avs_readdata,
    output logic        avs_waitrequest,
    output logic [1:0]  hpi_addr,
    output logic        hpi_cs_n,
    output logic        hpi_rd_n,
    output logic        hpi_wr_n,
    output logic [15:0] hpi_data_out,
    input  logic [15:0] hpi_data_in,
    output logic        hpi_data_oe,
    input  logic        hpi_int,
    output logic        irq
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        RECOVER
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic [3:0]  cnt_next;
    logic [1:0]  addr_q;
    logic [15:0] data_q;
    logic        write_q;
    logic        request;
    logic        last_cycle;
    logic        bus_active;
    logic [1:0]  int_sync;

    assign request    = avs_chipselect & (avs_read | avs_write);
    // The counter is loaded with N-1 on entry, so zero marks the final cycle.
    assign last_cycle = (cnt == 4'd0);

    // State and counter register. Asynchronous reset aborts any transaction,
    // and since all HPI outputs decode from this register they release at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic and decoded outputs.
    always_comb begin
        state_next      = state;
        cnt_next        = cnt - 4'd1;
        bus_active      = 1'b0;
        hpi_cs_n        = 1'b1;
        hpi_rd_n        = 1'b1;
        hpi_wr_n        = 1'b1;
        hpi_data_oe     = 1'b0;
        avs_waitrequest = request;

        case (state)
            IDLE: begin
                cnt_next = 4'd0;
                if (request) begin
                    state_next = SETUP;
                    cnt_next   = 4'(SETUP_CYC - 1);
                end
            end
            SETUP: begin
                bus_active = 1'b1;
                if (last_cycle) begin
                    state_next = STROBE;
                    cnt_next   = 4'(STROBE_CYC - 1);
                end
            end
            STROBE: begin
                bus_active = 1'b1;
                hpi_rd_n   = write_q;
                hpi_wr_n   = ~write_q;
                if (last_cycle) begin
                    state_next = HOLD;
                    cnt_next   = 4'(HOLD_CYC - 1);
                end
            end
            HOLD: begin
                bus_active = 1'b1;
                if (last_cycle) begin
                    // Completion: release the master for exactly this one cycle.
                    avs_waitrequest = 1'b0;
                    state_next      = RECOVER;
                    cnt_next        = 4'(RECOVERY_CYC - 1);
                end
            end
            RECOVER: begin
                if (last_cycle) begin
                    state_next = IDLE;
                    cnt_next   = 4'd0;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase

        if (bus_active) begin
            hpi_cs_n    = 1'b0;
            hpi_data_oe = write_q;
        end
    end

    // Write data is gated so the bus shows zero whenever it is not driven.
    assign hpi_data_out = hpi_data_oe ? data_q : 16'h0000;
    assign hpi_addr     = addr_q;

    // Transaction latch: captured only on acceptance in IDLE so that Avalon
    // input changes cannot disturb a cycle in flight. Write wins over read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q  <= 2'd0;
            data_q  <= 16'h0000;
            write_q <= 1'b0;
        end else if (state == IDLE && request) begin
            addr_q  <= avs_address;
            data_q  <= avs_writedata;
            write_q <= avs_write;
        end
    end

    // Read data is captured at the edge that ends the final strobe cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avs_readdata <= 16'h0000;
        end else if (state == STROBE && last_cycle && !write_q) begin
            avs_readdata <= hpi_data_in;
        end
    end

    // Two-flop synchronizer for the asynchronous HPI interrupt.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            int_sync <= 2'b00;
        end else begin
            int_sync <= {int_sync[0], hpi_int};
        end
    end

    assign irq = int_sync[1];

endmodule

// File: tb/tb_hpi_bus_sequencer.sv
// tb_hpi_bus_sequencer
//
// Directed self-checking bench for hpi_bus_sequencer with default timing
// (setup 1, strobe 4, hold 1, recovery 2). Inputs change 1 time unit after
// the rising edge; outputs are sampled on the falling edge. Cycle 0 is the
// cycle in which a request is first presented.

module tb_hpi_bus_sequencer;

    logic        clk;
    logic        reset_n;
    logic [1:0]  avs_address;
    logic        avs_chipselect;
    logic        avs_read;
    logic        avs_write;
    logic [15:0] avs_writedata;
    logic [15:0] avs_readdata;
    logic        avs_waitrequest;
    logic [1:0]  hpi_addr;
    logic        hpi_cs_n;
    logic        hpi_rd_n;
    logic        hpi_wr_n;
    logic [15:0] hpi_data_out;
    logic [15:0] hpi_data_in;
    logic        hpi_data_oe;
    logic        hpi_int;
    logic        irq;

    int total;
    int bad;
    logic [15:0] last_read;

    hpi_bus_sequencer dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .avs_address     (avs_address),
        .avs_chipselect  (avs_chipselect),
        .avs_read        (avs_read),
        .avs_write       (avs_write),
        .avs_writedata   (avs_writedata),
        .avs_readdata    (avs_readdata),
        .avs_waitrequest (avs_waitrequest),
        .hpi_addr        (hpi_addr),
        .hpi_cs_n        (hpi_cs_n),
        .hpi_rd_n        (hpi_rd_n),
        .hpi_wr_n        (hpi_wr_n),
        .hpi_data_out    (hpi_data_out),
        .hpi_data_in     (hpi_data_in),
        .hpi_data_oe     (hpi_data_oe),
        .hpi_int         (hpi_int),
        .irq             (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drop_request();
        avs_chipselect = 1'b0;
        avs_read       = 1'b0;
        avs_write      = 1'b0;
    endtask

    // Reset values with and without a pending request.
    task automatic test_reset();
        logic [40:0] obs;
        logic [40:0] exp;
        reset_n = 1'b0;
        drop_request();
        #12;
        obs = {hpi_cs_n, hpi_rd_n, hpi_wr_n, hpi_data_oe, avs_waitrequest, irq,
               hpi_addr, hpi_data_out, avs_readdata};
        exp = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 16'h0000};
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got %h want %h", obs, exp);
        end
        avs_chipselect = 1'b1;
        avs_read       = 1'b1;
        #1;
        total++;
        if (avs_waitrequest !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_wait_req: got %b want 1", avs_waitrequest);
        end
        drop_request();
        @(negedge clk);
        reset_n   = 1'b1;
        last_read = 16'h0000;
    endtask

    // Single write, checked every cycle from request to return to IDLE.
    task automatic test_write(input logic [1:0] a, input logic [15:0] d);
        logic [22:0] obs;
        logic [22:0] exp;
        logic        act;
        @(posedge clk); #1;
        avs_chipselect = 1'b1;
        avs_write      = 1'b1;
        avs_read       = 1'b0;
        avs_address    = a;
        avs_writedata  = d;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            act = (c >= 1 && c <= 6);
            exp = {!act, 1'b1, !(c >= 2 && c <= 5), act, (c <= 5),
                   act ? a : 2'd0, act ? d : 16'h0000};
            obs = {hpi_cs_n, hpi_rd_n, hpi_wr_n, hpi_data_oe, avs_waitrequest,
                   hpi_cs_n ? 2'd0 : hpi_addr, hpi_data_out};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("[TB] FAIL write_c%0d: got %h want %h", c, obs, exp);
            end
            @(posedge clk); #1;
            if (c == 1) begin
                // Changing the inputs mid-transaction must not affect the cycle.
                avs_address   = ~a;
                avs_writedata = ~d;
            end
            if (c == 6) drop_request();
        end
        total++;
        if (avs_readdata !== last_read) begin
            bad++;
            $display("[TB] FAIL write_keeps_readdata: got %h want %h", avs_readdata, last_read);
        end
    endtask

    // Single read, checked every cycle including the readdata capture point.
    task automatic test_read(input logic [1:0] a, input logic [15:0] din);
        logic [38:0] obs;
        logic [38:0] exp;
        logic        act;
        @(posedge clk); #1;
        avs_chipselect = 1'b1;
        avs_read       = 1'b1;
        avs_write      = 1'b0;
        avs_address    = a;
        hpi_data_in    = din;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            act = (c >= 1 && c <= 6);
            exp = {!act, !(c >= 2 && c <= 5), 1'b1, 1'b0, (c <= 5),
                   act ? a : 2'd0, 16'h0000, (c >= 6) ? din : last_read};
            obs = {hpi_cs_n, hpi_rd_n, hpi_wr_n, hpi_data_oe, avs_waitrequest,
                   hpi_cs_n ? 2'd0 : hpi_addr, hpi_data_out, avs_readdata};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("[TB] FAIL read_c%0d: got %h want %h", c, obs, exp);
            end
            @(posedge clk); #1;
            if (c == 6) begin
                drop_request();
                hpi_data_in = ~din;
            end
        end
        last_read = din;
    endtask

    // Write followed immediately by a held read: 9-cycle period.
    task automatic test_back_to_back();
        int   falls[2];
        int   nfall;
        int   done_c;
        logic prev_cs;
        logic [1:0]  addr2;
        logic [15:0] rdata;
        logic w7;
        logic w9;
        logic in_read;
        logic wait_s;
        nfall   = 0;
        done_c  = -1;
        prev_cs = 1'b1;
        in_read = 1'b0;
        addr2   = 2'd0;
        rdata   = 16'h0000;
        w7      = 1'b0;
        w9      = 1'b0;
        falls[0] = -1;
        falls[1] = -1;
        @(posedge clk); #1;
        avs_chipselect = 1'b1;
        avs_write      = 1'b1;
        avs_read       = 1'b0;
        avs_address    = 2'd3;
        avs_writedata  = 16'hA5A5;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            wait_s = avs_waitrequest;
            if (prev_cs && !hpi_cs_n && nfall < 2) begin
                falls[nfall] = c;
                if (nfall == 1) addr2 = hpi_addr;
                nfall++;
            end
            prev_cs = hpi_cs_n;
            if (c == 7) w7 = wait_s;
            if (c == 9) w9 = wait_s;
            if (in_read && !wait_s) begin
                done_c = c;
                rdata  = avs_readdata;
            end
            @(posedge clk); #1;
            if (!in_read && !wait_s) begin
                in_read     = 1'b1;
                avs_write   = 1'b0;
                avs_read    = 1'b1;
                avs_address = 2'd1;
                hpi_data_in = 16'h1357;
            end else if (in_read && !wait_s) begin
                drop_request();
                break;
            end
        end
        drop_request();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (falls[0] !== 1) begin
            bad++;
            $display("[TB] FAIL b2b_first_fall: got %0d want 1", falls[0]);
        end
        total++;
        if (falls[1] - falls[0] !== 9) begin
            bad++;
            $display("[TB] FAIL b2b_period: got %0d want 9", falls[1] - falls[0]);
        end
        total++;
        if (addr2 !== 2'd1) begin
            bad++;
            $display("[TB] FAIL b2b_read_addr: got %0d want 1", addr2);
        end
        total++;
        if ({w7, w9} !== 2'b11) begin
            bad++;
            $display("[TB] FAIL b2b_stall: got %b want 11", {w7, w9});
        end
        total++;
        if (done_c !== 15) begin
            bad++;
            $display("[TB] FAIL b2b_done_cycle: got %0d want 15", done_c);
        end
        total++;
        if (rdata !== 16'h1357) begin
            bad++;
            $display("[TB] FAIL b2b_readdata: got %h want 1357", rdata);
        end
        last_read = 16'h1357;
    endtask

    // Read and write together at address 1 become a write only.
    task automatic test_simultaneous();
        int rd_low;
        int wr_low;
        int oe_hi;
        logic [1:0] addr_seen;
        rd_low    = 0;
        wr_low    = 0;
        oe_hi     = 0;
        addr_seen = 2'd0;
        @(posedge clk); #1;
        avs_chipselect = 1'b1;
        avs_read       = 1'b1;
        avs_write      = 1'b1;
        avs_address    = 2'd1;
        avs_writedata  = 16'h0042;
        hpi_data_in    = 16'hDEAD;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (!hpi_rd_n) rd_low++;
            if (!hpi_wr_n) begin
                wr_low++;
                addr_seen = hpi_addr;
            end
            if (hpi_data_oe && hpi_data_out === 16'h0042) oe_hi++;
            @(posedge clk); #1;
            if (c == 6) drop_request();
        end
        total++;
        if ({rd_low, wr_low, oe_hi} !== {32'd0, 32'd4, 32'd6}) begin
            bad++;
            $display("[TB] FAIL rdwr_is_write: got rd=%0d wr=%0d oe=%0d want rd=0 wr=4 oe=6",
                     rd_low, wr_low, oe_hi);
        end
        total++;
        if (addr_seen !== 2'd1) begin
            bad++;
            $display("[TB] FAIL rdwr_addr: got %0d want 1", addr_seen);
        end
        total++;
        if (avs_readdata !== last_read) begin
            bad++;
            $display("[TB] FAIL rdwr_readdata: got %h want %h", avs_readdata, last_read);
        end
    endtask

    // Reset pulse in cycle 3 of a write aborts it immediately, no retry.
    task automatic test_reset_abort();
        logic [37:0] obs;
        logic [37:0] exp;
        int cs_low;
        cs_low = 0;
        @(posedge clk); #1;
        avs_chipselect = 1'b1;
        avs_write      = 1'b1;
        avs_read       = 1'b0;
        avs_address    = 2'd2;
        avs_writedata  = 16'h7777;
        repeat (3) begin
            @(posedge clk); #1;
        end
        #1;
        total++;
        if (hpi_wr_n !== 1'b0) begin
            bad++;
            $display("[TB] FAIL abort_pre_strobe: got wr_n=%b want 0", hpi_wr_n);
        end
        reset_n = 1'b0;
        drop_request();
        #1;
        obs = {hpi_cs_n, hpi_rd_n, hpi_wr_n, hpi_data_oe, avs_waitrequest,
               hpi_addr, hpi_data_out, avs_readdata};
        exp = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000, 16'h0000};
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL abort_release: got %h want %h", obs, exp);
        end
        @(negedge clk);
        reset_n   = 1'b1;
        last_read = 16'h0000;
        repeat (4) begin
            @(negedge clk);
            if (!hpi_cs_n) cs_low++;
        end
        total++;
        if (cs_low !== 0) begin
            bad++;
            $display("[TB] FAIL abort_no_retry: got %0d cs_n low cycles want 0", cs_low);
        end
    endtask

    // Interrupt synchronizer: irq follows hpi_int after two rising edges.
    task automatic test_irq();
        logic s1;
        logic s2;
        for (int v = 1; v >= 0; v--) begin
            @(posedge clk); #3;
            hpi_int = 1'(v);
            @(negedge clk);
            @(negedge clk);
            s1 = irq;
            @(negedge clk);
            s2 = irq;
            total++;
            if ({s1, s2} !== {1'(1 - v), 1'(v)}) begin
                bad++;
                $display("[TB] FAIL irq_sync_%0d: got %b%b want %b%b",
                         v, s1, s2, 1'(1 - v), 1'(v));
            end
        end
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        last_read      = 16'h0000;
        reset_n        = 1'b0;
        avs_address    = 2'd0;
        avs_chipselect = 1'b0;
        avs_read       = 1'b0;
        avs_write      = 1'b0;
        avs_writedata  = 16'h0000;
        hpi_data_in    = 16'h0000;
        hpi_int        = 1'b0;

        test_reset();
        test_write(2'd2, 16'h1234);
        test_read(2'd0, 16'hBEEF);
        test_write(2'd3, 16'hC0DE);
        test_back_to_back();
        test_simultaneous();
        test_reset_abort();
        test_write(2'd1, 16'h0F0F);
        test_irq();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
